// File: rtl/fetch_unit_redirect_pkg.sv
// Shared types and constants for the redirecting fetch unit.
// Optional feature macro: FETCH_UNIT_REDIRECT_BYPASS_EN (see fetch_unit_redirect.sv).
package fetch_unit_redirect_pkg;

    localparam logic [31:0] FETCH_RST_ADDR  = 32'h0000_0200;
    localparam logic [31:0] FETCH_ADDR_INCR = 32'd4;

    typedef enum logic [2:0] {
        MEM_MSG_READ  = 3'd0,
        MEM_MSG_WRITE = 3'd1
    } mem_msg_type_t;

    typedef struct packed {
        mem_msg_type_t op;
        logic [7:0]    opaque;
        logic [31:0]   addr;
        logic [1:0]    len;
        logic [31:0]   data;
    } mem_req_msg_t;

    typedef struct packed {
        mem_msg_type_t op;
        logic [7:0]    opaque;
        logic [1:0]    test;
        logic [1:0]    len;
        logic [31:0]   data;
        logic [31:0]   addr;
    } mem_resp_msg_t;

    // Counter width able to hold every value from 0 up to max_in_flight.
    function automatic int inflight_width(input int max_in_flight);
        return $clog2(max_in_flight + 1);
    endfunction

endpackage

// File: rtl/fetch_unit_redirect_if.sv
// Memory request/response interface and fetch-to-decode interface.
// Optional feature macro: FETCH_UNIT_REDIRECT_BYPASS_EN (no effect here).
interface MemIntf;
    import fetch_unit_redirect_pkg::*;

    logic          req_val;
    logic          req_rdy;
    mem_req_msg_t  req_msg;
    logic          resp_val;
    logic          resp_rdy;
    mem_resp_msg_t resp_msg;

    modport client (output req_val, req_msg, resp_rdy,
                    input  req_rdy, resp_val, resp_msg);
    modport server (input  req_val, req_msg, resp_rdy,
                    output req_rdy, resp_val, resp_msg);
endinterface

interface F__DIntf #(parameter int p_seq_num_bits = 5);
    logic                      val;
    logic                      rdy;
    logic [31:0]               inst;
    logic [31:0]               pc;
    logic [p_seq_num_bits-1:0] seq_num;

    modport F_intf (output val, inst, pc, seq_num, input rdy);
    modport D_intf (input  val, inst, pc, seq_num, output rdy);
endinterface

// File: rtl/fetch_unit_redirect_inflight_tracker.sv
// Counts outstanding memory requests and how many of them are stale after a redirect.
// Optional feature macro: FETCH_UNIT_REDIRECT_BYPASS_EN changes the squash count on redirect.
module fetch_inflight_tracker
    import fetch_unit_redirect_pkg::*;
#(
    parameter int p_max_in_flight = 4,
    parameter int p_cnt_bits      = inflight_width(p_max_in_flight)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_xfer,
    input  logic                  resp_xfer,
    input  logic                  redirect,
    output logic [p_cnt_bits-1:0] in_flight,
    output logic [p_cnt_bits-1:0] squash_cnt,
    output logic                  can_issue,
    output logic                  drop
);

    localparam logic [p_cnt_bits-1:0] MAX_CNT = p_cnt_bits'(p_max_in_flight);

    logic [p_cnt_bits-1:0] in_flight_nxt;
    logic [p_cnt_bits-1:0] squash_on_redirect;

    always_comb begin
        in_flight_nxt = in_flight + p_cnt_bits'(req_xfer) - p_cnt_bits'(resp_xfer);
`ifdef FETCH_UNIT_REDIRECT_BYPASS_EN
        // The redirect-cycle request already targets the new PC, so it is not stale.
        squash_on_redirect = in_flight - p_cnt_bits'(resp_xfer);
`else
        squash_on_redirect = in_flight_nxt;
`endif
        can_issue = (in_flight < MAX_CNT);
        drop      = (squash_cnt != '0) || redirect;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_flight  <= '0;
            squash_cnt <= '0;
        end else begin
            in_flight <= in_flight_nxt;
            if (redirect)
                squash_cnt <= squash_on_redirect;
            else if (resp_xfer && (squash_cnt != '0))
                squash_cnt <= squash_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit_redirect.sv
// Sequential instruction fetch with bounded outstanding requests, redirect squashing and seq tags.
// Optional feature macro: FETCH_UNIT_REDIRECT_BYPASS_EN issues the redirect target in the redirect cycle.
module fetch_unit_redirect
    import fetch_unit_redirect_pkg::*;
#(
    parameter logic [31:0] p_rst_addr      = FETCH_RST_ADDR,
    parameter int          p_max_in_flight = 4,
    parameter int          p_seq_num_bits  = 5
) (
    input  logic        clk,
    input  logic        rst,
    MemIntf.client      mem,
    F__DIntf.F_intf     D,
    input  logic        redirect_val,
    input  logic [31:0] redirect_target
);

    localparam int CNT_BITS = inflight_width(p_max_in_flight);

    logic [31:0]               curr_addr;
    logic [p_seq_num_bits-1:0] seq_num;
    logic [CNT_BITS-1:0]       in_flight;
    logic [CNT_BITS-1:0]       squash_cnt;
    logic                      can_issue;
    logic                      drop;
    logic                      req_val;
    logic [31:0]               req_addr;
    logic                      resp_rdy;
    logic                      d_val;
    logic                      req_xfer;
    logic                      resp_xfer;
    logic                      d_xfer;
    logic                      unused_resp;

    fetch_inflight_tracker #(
        .p_max_in_flight (p_max_in_flight),
        .p_cnt_bits      (CNT_BITS)
    ) u_tracker (
        .clk        (clk),
        .rst        (rst),
        .req_xfer   (req_xfer),
        .resp_xfer  (resp_xfer),
        .redirect   (redirect_val),
        .in_flight  (in_flight),
        .squash_cnt (squash_cnt),
        .can_issue  (can_issue),
        .drop       (drop)
    );

    // Handshakes are gated by rst so nothing is presented while reset is held.
    always_comb begin
        req_addr = curr_addr;
`ifdef FETCH_UNIT_REDIRECT_BYPASS_EN
        req_val = rst && can_issue;
        if (redirect_val)
            req_addr = redirect_target;
`else
        req_val = rst && can_issue && !redirect_val;
`endif
        resp_rdy  = rst && (drop || D.rdy);
        d_val     = rst && !drop && mem.resp_val;
        req_xfer  = req_val && mem.req_rdy;
        resp_xfer = mem.resp_val && resp_rdy;
        d_xfer    = d_val && D.rdy;
    end

    assign mem.req_val  = req_val;
    assign mem.req_msg  = '{op: MEM_MSG_READ, opaque: 8'd0, addr: req_addr, len: 2'd0, data: 32'd0};
    assign mem.resp_rdy = resp_rdy;

    assign D.val     = d_val;
    assign D.inst    = mem.resp_msg.data;
    assign D.pc      = mem.resp_msg.addr;
    assign D.seq_num = seq_num;

    assign unused_resp = ^{mem.resp_msg.op, mem.resp_msg.opaque, mem.resp_msg.test,
                           mem.resp_msg.len, squash_cnt};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            curr_addr <= p_rst_addr;
        end else if (redirect_val) begin
`ifdef FETCH_UNIT_REDIRECT_BYPASS_EN
            curr_addr <= req_xfer ? (redirect_target + FETCH_ADDR_INCR) : redirect_target;
`else
            curr_addr <= redirect_target;
`endif
        end else if (req_xfer) begin
            curr_addr <= curr_addr + FETCH_ADDR_INCR;
        end
    end

    // Sequence numbers count delivered instructions only and survive redirects.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            seq_num <= '0;
        else if (d_xfer)
            seq_num <= seq_num + 1'b1;
    end

endmodule

// File: tb/tb_fetch_unit_redirect.sv
// Randomised scoreboard bench for fetch_unit_redirect with an in-order memory model.
// Honours FETCH_UNIT_REDIRECT_BYPASS_EN when the same macro is defined for the bench.
module tb_fetch_unit_redirect;
    import fetch_unit_redirect_pkg::*;

`ifdef FETCH_UNIT_REDIRECT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int MAX_IF = 4;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } pend_t;

    logic        clk;
    logic        rst;
    logic        redirect_val;
    logic [31:0] redirect_target;

    MemIntf mem_if ();
    F__DIntf #(.p_seq_num_bits(5)) d_if ();

    fetch_unit_redirect #(
        .p_rst_addr      (32'h200),
        .p_max_in_flight (MAX_IF),
        .p_seq_num_bits  (5)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .mem             (mem_if.client),
        .D               (d_if.F_intf),
        .redirect_val    (redirect_val),
        .redirect_target (redirect_target)
    );

    int          total;
    int          bad;
    pend_t       mem_q[$];
    logic [31:0] sb_q[$];
    logic [31:0] next_pc;
    logic [4:0]  exp_seq;

    logic        req_x, resp_x, d_x, front_stale, exp_req_val, exp_dval, exp_resp_rdy;
    logic [31:0] exp_addr, exp_pc;
    pend_t       ent;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_F00D;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: every outstanding request is live or stale, and a redirect makes all of them stale.
    always @(negedge clk) begin
        if (rst) begin
            req_x  = mem_if.req_val && mem_if.req_rdy;
            resp_x = mem_if.resp_val && mem_if.resp_rdy;
            d_x    = d_if.val && d_if.rdy;

            exp_req_val = (mem_q.size() < MAX_IF) && (BYP || !redirect_val);
            exp_addr    = (BYP && redirect_val) ? redirect_target : next_pc;
            checkOutput("req_val", 32'(mem_if.req_val), 32'(exp_req_val));
            if (mem_if.req_val) begin
                checkOutput("req_addr", mem_if.req_msg.addr, exp_addr);
                checkOutput("req_op", 32'(mem_if.req_msg.op), 32'(MEM_MSG_READ));
            end

            front_stale  = (mem_q.size() > 0) && mem_q[0].stale;
            exp_dval     = mem_if.resp_val && !front_stale && !redirect_val;
            exp_resp_rdy = (front_stale || redirect_val) ? 1'b1 : d_if.rdy;
            checkOutput("d_val", 32'(d_if.val), 32'(exp_dval));
            checkOutput("resp_rdy", 32'(mem_if.resp_rdy), 32'(exp_resp_rdy));

            if (d_x) begin
                if (sb_q.size() == 0) begin
                    checkOutput("sb_underflow", d_if.pc, 32'hDEAD_BEEF);
                end else begin
                    exp_pc = sb_q.pop_front();
                    checkOutput("d_pc", d_if.pc, exp_pc);
                    checkOutput("d_inst", d_if.inst, inst_of(exp_pc));
                    checkOutput("d_seq", 32'(d_if.seq_num), 32'(exp_seq));
                end
                exp_seq = exp_seq + 5'd1;
            end

            if (resp_x && mem_q.size() > 0) void'(mem_q.pop_front());
            if (redirect_val) begin
                foreach (mem_q[i]) mem_q[i].stale = 1'b1;
                sb_q.delete();
                next_pc = redirect_target;
            end
            if (req_x) begin
                ent.addr  = mem_if.req_msg.addr;
                ent.stale = redirect_val && !BYP;
                mem_q.push_back(ent);
                if (!ent.stale) sb_q.push_back(exp_addr);
                next_pc = exp_addr + 32'd4;
            end
        end
    end

    // Mode 0: ideal memory; 1: responses stalled; 2: random; 3: stalled + redirect 0x1000; 4: ideal + redirect 0x2000.
    task automatic applyStimulus(input int mode);
        @(posedge clk);
        #1;
        redirect_val    = 1'b0;
        mem_if.req_rdy  = 1'b1;
        d_if.rdy        = 1'b1;
        case (mode)
            2: begin
                mem_if.req_rdy = ($urandom % 4) != 0;
                d_if.rdy       = ($urandom % 4) != 0;
                redirect_val   = ($urandom % 8) == 0;
                if ($urandom % 8 == 0)
                    redirect_target = 32'hFFFF_FFF8;
                else
                    redirect_target = 32'h1000 + (32'($urandom_range(0, 255)) << 2);
            end
            3: begin
                redirect_val    = 1'b1;
                redirect_target = 32'h1000;
            end
            4: begin
                redirect_val    = 1'b1;
                redirect_target = 32'h2000;
            end
            default: ;
        endcase
        mem_if.resp_val = (mode != 1) && (mode != 3) && (mem_q.size() > 0) &&
                          ((mode != 2) || (($urandom % 4) != 0));
        if (mem_q.size() > 0) begin
            mem_if.resp_msg.addr = mem_q[0].addr;
            mem_if.resp_msg.data = inst_of(mem_q[0].addr);
        end
    endtask

    task automatic midReset();
        @(posedge clk);
        #1;
        rst             = 1'b0;
        redirect_val    = 1'b0;
        mem_if.resp_val = 1'b0;
        #1;
        checkOutput("rst_req_val", 32'(mem_if.req_val), 32'd0);
        checkOutput("rst_resp_rdy", 32'(mem_if.resp_rdy), 32'd0);
        checkOutput("rst_d_val", 32'(d_if.val), 32'd0);
        mem_q.delete();
        sb_q.delete();
        next_pc = 32'h200;
        exp_seq = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        next_pc = 32'h200;
        exp_seq = 5'd0;
        rst = 1'b0;
        redirect_val = 1'b0;
        redirect_target = 32'h0;
        mem_if.req_rdy = 1'b0;
        mem_if.resp_val = 1'b0;
        mem_if.resp_msg = '0;
        d_if.rdy = 1'b0;
        #2;
        checkOutput("init_req_val", 32'(mem_if.req_val), 32'd0);
        checkOutput("init_d_val", 32'(d_if.val), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        repeat (10) applyStimulus(0);
        repeat (8)  applyStimulus(1);
        applyStimulus(3);
        applyStimulus(0);
        applyStimulus(4);
        repeat (12) applyStimulus(0);
        repeat (600) applyStimulus(2);
        repeat (3) applyStimulus(0);
        midReset();
        repeat (6) applyStimulus(0);
        repeat (600) applyStimulus(2);
        repeat (12) applyStimulus(0);

        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
